// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-ported data memory.
// Optional per-requester grant counters are built when ARB_COUNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
`ifdef ARB_COUNT_EN
    output logic              owner,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`else
    output logic              owner
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_C = 4'(MEM_LAT);

    state_t      state_r;
    state_t      state_next_s;
    logic        last_r;
    logic        we_r;
    logic [3:0]  cnt_r;
    logic        grant_s;
    logic        sel_s;
    logic        sel_we_s;

    // Arbitration and next-state decode; on a tie the requester not granted last wins.
    always_comb begin
        grant_s      = 1'b0;
        sel_s        = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0 && req1) begin
                    grant_s = 1'b1;
                    sel_s   = ~last_r;
                end else if (req0) begin
                    grant_s = 1'b1;
                    sel_s   = 1'b0;
                end else if (req1) begin
                    grant_s = 1'b1;
                    sel_s   = 1'b1;
                end else begin
                    grant_s = 1'b0;
                    sel_s   = 1'b0;
                end
                if (grant_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: state_next_s = WAIT;
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    assign sel_we_s = sel_s ? we1 : we0;

    // State register plus all registered outputs; strobes and done are single-cycle pulses.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            last_r    <= 1'b1;
            we_r      <= 1'b0;
            cnt_r     <= 4'd0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= {DATA_W{1'b0}};
            rdata1    <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            busy      <= (state_next_s != IDLE);
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner     <= sel_s;
                        we_r      <= sel_we_s;
                        mem_addr  <= sel_s ? addr1 : addr0;
                        mem_wdata <= sel_s ? wdata1 : wdata0;
                        mem_read  <= ~sel_we_s;
                        mem_write <= sel_we_s;
                    end
                end
                ACCESS: cnt_r <= LAT_C;
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        // Read data is valid in the last WAIT cycle.
                        if (!we_r && owner) begin
                            rdata1 <= mem_rdata;
                        end
                        if (!we_r && !owner) begin
                            rdata0 <= mem_rdata;
                        end
                        done0 <= ~owner;
                        done1 <= owner;
                    end
                end
                RESP:    last_r <= owner;
                default: last_r <= last_r;
            endcase
        end
    end

`ifdef ARB_COUNT_EN
    // Saturating per-requester grant counters, stepped on each IDLE to ACCESS grant.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (state_r == IDLE && grant_s) begin
            if (!sel_s && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (sel_s && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=4 instances).
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        Reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1, mem_rdata;

    logic        done0, done1, mem_read, mem_write, busy, owner;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic        done0_4, done1_4, mem_read_4, mem_write_4, busy_4, owner_4;
    logic [31:0] rdata0_4, rdata1_4, mem_addr_4, mem_wdata_4;
`ifdef ARB_COUNT_EN
    logic [15:0] grant_cnt0, grant_cnt1, grant_cnt0_4, grant_cnt1_4;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
        .clock(clock), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy),
`ifdef ARB_COUNT_EN
        .owner(owner), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`else
        .owner(owner)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
        .clock(clock), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0_4), .rdata0(rdata0_4),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1_4), .rdata1(rdata1_4),
        .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4), .mem_read(mem_read_4), .mem_write(mem_write_4),
        .mem_rdata(mem_rdata), .busy(busy_4),
`ifdef ARB_COUNT_EN
        .owner(owner_4), .grant_cnt0(grant_cnt0_4), .grant_cnt1(grant_cnt1_4)
`else
        .owner(owner_4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        mem_rdata = 32'h0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        check("rst_done", 64'({done0, done1}), 64'd0);
        check("rst_rdata0", 64'(rdata0), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        Reset = 1'b0;

        // single read from requester 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80; mem_rdata = 32'hDEADBEEF;
        tick;
        check("rd_mem_read", 64'(mem_read), 64'd1);
        check("rd_mem_write", 64'(mem_write), 64'd0);
        check("rd_addr", 64'(mem_addr), 64'h80);
        check("rd_busy", 64'(busy), 64'd1);
        tick;
        check("rd_strobe_once", 64'(mem_read), 64'd0);
        check("rd_done_early", 64'(done0), 64'd0);
        tick;
        check("rd_done0", 64'(done0), 64'd1);
        check("rd_done1", 64'(done1), 64'd0);
        check("rd_rdata0", 64'(rdata0), 64'hDEADBEEF);
        req0 = 1'b0;
        tick;
        check("rd_done_pulse", 64'(done0), 64'd0);
        check("rd_idle", 64'(busy), 64'd0);
        check("rd_hold_rdata", 64'(rdata0), 64'hDEADBEEF);

        // write from requester 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h12345678;
        tick;
        check("wr_mem_write", 64'(mem_write), 64'd1);
        check("wr_mem_read", 64'(mem_read), 64'd0);
        check("wr_wdata", 64'(mem_wdata), 64'h12345678);
        check("wr_addr", 64'(mem_addr), 64'h10);
        check("wr_owner", 64'(owner), 64'd1);
        tick;
        check("wr_strobe_once", 64'(mem_write), 64'd0);
        tick;
        check("wr_done1", 64'(done1), 64'd1);
        check("wr_done0", 64'(done0), 64'd0);
        check("wr_rdata1", 64'(rdata1), 64'd0);
        req1 = 1'b0;
        tick;
        check("wr_hold_addr", 64'(mem_addr), 64'h10);

        // simultaneous requests after reset alternate 0,1,0,1
        Reset = 1'b1; #1; Reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; mem_rdata = 32'h0A0B0C0D;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_owner", 64'(owner), 64'(k % 2));
            check("rr_strobe", 64'(mem_read), 64'd1);
            tick;
            tick;
            check("rr_done", 64'({done0, done1}), (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick;
            check("rr_idle", 64'(busy), 64'd0);
        end
        check("rr_rdata1", 64'(rdata1), 64'h0A0B0C0D);

        // reset mid-WAIT
        req0 = 1'b1; we0 = 1'b0; mem_rdata = 32'h55AA55AA;
        tick;
        tick;
        check("rw_in_wait", 64'(busy), 64'd1);
        Reset = 1'b1;
        #1;
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_strobes", 64'({mem_read, mem_write}), 64'd0);
        check("rw_done", 64'({done0, done1}), 64'd0);
        check("rw_rdata0", 64'(rdata0), 64'd0);
        check("rw_rdata1", 64'(rdata1), 64'd0);
        req1 = 1'b1;
        tick;
        check("rw_no_done", 64'({done0, done1}), 64'd0);
        Reset = 1'b0;
        tick;
        check("rw_first_owner", 64'(owner), 64'd0);
        check("rw_first_busy", 64'(busy), 64'd1);
        tick;
        tick;
        check("rw_done0", 64'(done0), 64'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick;

        // MEM_LAT=4 read on the second instance
        Reset = 1'b1; #1; Reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44; mem_rdata = 32'h0;
        tick;
        check("l4_strobe", 64'(mem_read_4), 64'd1);
        check("l4_addr", 64'(mem_addr_4), 64'h44);
        tick;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'h1000 + 32'(i);
            tick;
            if (i < 3) begin
                check("l4_wait", 64'(done0_4), 64'd0);
            end else begin
                check("l4_done", 64'(done0_4), 64'd1);
                check("l4_rdata", 64'(rdata0_4), 64'h1003);
            end
        end
        req0 = 1'b0;
        tick;
        check("l4_idle", 64'({busy_4, done0_4}), 64'd0);

`ifdef ARB_COUNT_EN
        // grant counters: 3 grants to 0, 2 to 1, then saturation
        repeat (4) tick;
        Reset = 1'b1; #1; Reset = 1'b0;
        req0 = 1'b1;
        repeat (3 * 4) tick;
        req0 = 1'b0; req1 = 1'b1;
        repeat (2 * 4) tick;
        req1 = 1'b0;
        tick;
        check("cnt0", 64'(grant_cnt0), 64'd3);
        check("cnt1", 64'(grant_cnt1), 64'd2);
        force u_dut.grant_cnt0 = 16'hFFFF;
        #1;
        release u_dut.grant_cnt0;
        req0 = 1'b1;
        repeat (4) tick;
        req0 = 1'b0;
        check("cnt0_sat", 64'(grant_cnt0), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
